// File: rtl/pll_lock_sequencer_if.sv
// Control/status bundle between the PLL lock sequencer and its surroundings.
// The master side drives lock/restart/clear inputs; the slave (sequencer) drives status.
interface pll_lock_sequencer_if #(
  parameter int RW = 2
);
  logic          locked_in;
  logic          restart;
  logic          clr_lost;
  logic          pll_areset;
  logic          pll_ready;
  logic          lock_lost;
  logic          fail;
  logic [RW-1:0] retry_cnt;
  logic [2:0]    state_o;

  modport master (
    output locked_in, restart, clr_lost,
    input  pll_areset, pll_ready, lock_lost, fail, retry_cnt, state_o
  );

  modport slave (
    input  locked_in, restart, clr_lost,
    output pll_areset, pll_ready, lock_lost, fail, retry_cnt, state_o
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL start-up/recovery sequencer: pulses the PLL reset, waits for and qualifies lock,
// publishes pll_ready, and retries timed-out attempts before declaring failure.
//   state     | meaning
//   RESET_PLL | pll_areset held for RST_CYCLES
//   WAIT_LOCK | waiting for synchronized lock, bounded by LOCK_TIMEOUT
//   STABLE    | lock must stay high for LOCK_STABLE consecutive cycles
//   READY     | PLL usable; lock drop restarts the sequence
//   FAIL      | retries exhausted; held until restart or reset
module pll_lock_sequencer #(
  parameter int RST_CYCLES   = 10,
  parameter int LOCK_TIMEOUT = 50000,
  parameter int LOCK_STABLE  = 64,
  parameter int MAX_RETRY    = 3
) (
  input logic                  clk,
  input logic                  rst_n,
  pll_lock_sequencer_if.slave  bus
);
  localparam int RW   = $clog2(MAX_RETRY + 1);
  localparam int M1   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int CMAX = (M1 > LOCK_STABLE) ? M1 : LOCK_STABLE;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_READY     = 3'd3,
    S_FAIL      = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          lost_q, lost_d;
  logic          areset_q, areset_d;
  logic          ready_q, ready_d;
  logic          fail_q, fail_d;
  logic          lock_meta_q, locked_s_q;
  logic          drop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_RESET_PLL;
      cnt_q       <= '0;
      retry_q     <= '0;
      lost_q      <= 1'b0;
      areset_q    <= 1'b1;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
      lock_meta_q <= 1'b0;
      locked_s_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      lost_q      <= lost_d;
      areset_q    <= areset_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
      lock_meta_q <= bus.locked_in;
      locked_s_q  <= lock_meta_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    retry_d = retry_q;
    drop    = (state_q == S_READY) && !locked_s_q;
    case (state_q)
      S_RESET_PLL: begin
        if (cnt_q == CW'(RST_CYCLES - 1)) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      S_WAIT_LOCK: begin
        if (locked_s_q) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
          cnt_d = '0;
          if (retry_q == RW'(MAX_RETRY)) begin
            state_d = S_FAIL;
          end else begin
            state_d = S_RESET_PLL;
            retry_d = retry_q + RW'(1);
          end
        end
      end
      S_STABLE: begin
        if (!locked_s_q) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CW'(LOCK_STABLE - 1)) begin
          state_d = S_READY;
          cnt_d   = '0;
          retry_d = '0;
        end
      end
      S_READY: begin
        cnt_d = '0;
        if (drop) state_d = S_RESET_PLL;
      end
      S_FAIL: cnt_d = '0;
      default: begin
        state_d = S_RESET_PLL;
        cnt_d   = '0;
      end
    endcase

    if (bus.restart) begin
      state_d = S_RESET_PLL;
      cnt_d   = '0;
      retry_d = '0;
    end

    // A real lock loss is recorded even when restart or clr_lost coincide.
    lost_d = lost_q;
    if (drop)              lost_d = 1'b1;
    else if (bus.clr_lost) lost_d = 1'b0;

    areset_d = (state_d == S_RESET_PLL) || (state_d == S_FAIL);
    ready_d  = (state_d == S_READY);
    fail_d   = (state_d == S_FAIL);
  end

  assign bus.pll_areset = areset_q;
  assign bus.pll_ready  = ready_q;
  assign bus.lock_lost  = lost_q;
  assign bus.fail       = fail_q;
  assign bus.retry_cnt  = retry_q;
  assign bus.state_o    = state_q;
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: timed expectations are queued per scenario
// and popped/compared at the cycle they fall due (cycle 0 = first sample after reset).
module tb_pll_lock_sequencer;
  localparam int RST_CYCLES   = 4;
  localparam int LOCK_TIMEOUT = 20;
  localparam int LOCK_STABLE  = 8;
  localparam int MAX_RETRY    = 2;
  localparam int RW           = $clog2(MAX_RETRY + 1);

  localparam int F_STATE  = 0;
  localparam int F_ARESET = 1;
  localparam int F_READY  = 2;
  localparam int F_LOST   = 3;
  localparam int F_FAIL   = 4;
  localparam int F_RETRY  = 5;

  typedef struct {
    int cyc;
    int sel;
    int val;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  pll_lock_sequencer_if #(.RW(RW)) bus ();

  pll_lock_sequencer #(
    .RST_CYCLES  (RST_CYCLES),
    .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .LOCK_STABLE (LOCK_STABLE),
    .MAX_RETRY   (MAX_RETRY)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] fld(int sel);
    case (sel)
      F_STATE:  return {29'd0, bus.state_o};
      F_ARESET: return {31'd0, bus.pll_areset};
      F_READY:  return {31'd0, bus.pll_ready};
      F_LOST:   return {31'd0, bus.lock_lost};
      F_FAIL:   return {31'd0, bus.fail};
      default:  return {{(32-RW){1'b0}}, bus.retry_cnt};
    endcase
  endfunction

  function automatic string fname(int sel);
    case (sel)
      F_STATE:  return "state_o";
      F_ARESET: return "pll_areset";
      F_READY:  return "pll_ready";
      F_LOST:   return "lock_lost";
      F_FAIL:   return "fail";
      default:  return "retry_cnt";
    endcase
  endfunction

  function automatic void ex(int cyc, int sel, int val);
    exp_t e;
    e.cyc = cyc;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.restart   = 1'b0;
    bus.clr_lost  = 1'b0;
    bus.locked_in = 1'b0;
    sb.delete();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [31:0] act;
    do_reset();
    ex(0, F_STATE, 0); ex(0, F_ARESET, 1); ex(0, F_READY, 0);
    ex(0, F_LOST, 0);  ex(0, F_FAIL, 0);   ex(0, F_RETRY, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      act = fld(e.sel);
      n_cmp++;
      if (act !== 32'(e.val)) begin
        n_bad++;
        $display("FAIL reset %s @c0: got %0d, want %0d", fname(e.sel), act, e.val);
      end
    end
  endtask

  task automatic test_lock_basic();
    exp_t e;
    logic [31:0] act;
    do_reset();
    ex(1, F_ARESET, 1); ex(3, F_ARESET, 1); ex(3, F_STATE, 0);
    ex(4, F_ARESET, 0); ex(4, F_STATE, 1);
    ex(12, F_STATE, 1); ex(13, F_STATE, 2);
    ex(20, F_READY, 0); ex(20, F_STATE, 2);
    ex(21, F_READY, 1); ex(21, F_STATE, 3); ex(21, F_RETRY, 0); ex(21, F_ARESET, 0);
    for (int c = 1; c <= 21; c++) begin
      bus.locked_in = (c >= 11);
      tick();
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        act = fld(e.sel);
        n_cmp++;
        if (act !== 32'(e.val)) begin
          n_bad++;
          $display("FAIL lock_basic %s @c%0d: got %0d, want %0d", fname(e.sel), c, act, e.val);
        end
      end
    end
  endtask

  task automatic test_timeout_fail();
    exp_t e;
    logic [31:0] act;
    do_reset();
    ex(23, F_RETRY, 0); ex(23, F_STATE, 1);
    ex(24, F_RETRY, 1); ex(24, F_STATE, 0); ex(24, F_ARESET, 1);
    ex(27, F_STATE, 0); ex(28, F_STATE, 1);
    ex(47, F_RETRY, 1); ex(48, F_RETRY, 2); ex(48, F_STATE, 0);
    ex(71, F_STATE, 1); ex(71, F_FAIL, 0);
    ex(72, F_STATE, 4); ex(72, F_FAIL, 1); ex(72, F_ARESET, 1); ex(72, F_READY, 0); ex(72, F_RETRY, 2);
    ex(80, F_STATE, 4); ex(80, F_FAIL, 1);
    ex(81, F_STATE, 0); ex(81, F_FAIL, 0); ex(81, F_RETRY, 0); ex(81, F_ARESET, 1);
    for (int c = 1; c <= 81; c++) begin
      bus.restart = (c == 81);
      tick();
      bus.restart = 1'b0;
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        act = fld(e.sel);
        n_cmp++;
        if (act !== 32'(e.val)) begin
          n_bad++;
          $display("FAIL timeout %s @c%0d: got %0d, want %0d", fname(e.sel), c, act, e.val);
        end
      end
    end
  endtask

  task automatic test_glitch();
    exp_t e;
    logic [31:0] act;
    do_reset();
    ex(13, F_STATE, 2); ex(17, F_STATE, 2); ex(18, F_STATE, 1);
    ex(19, F_STATE, 2); ex(26, F_STATE, 2); ex(26, F_READY, 0);
    ex(27, F_STATE, 3); ex(27, F_READY, 1); ex(27, F_RETRY, 0);
    for (int c = 1; c <= 27; c++) begin
      bus.locked_in = (c >= 11) && (c != 16);
      tick();
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        act = fld(e.sel);
        n_cmp++;
        if (act !== 32'(e.val)) begin
          n_bad++;
          $display("FAIL glitch %s @c%0d: got %0d, want %0d", fname(e.sel), c, act, e.val);
        end
      end
    end
  endtask

  task automatic test_lock_loss();
    exp_t e;
    logic [31:0] act;
    do_reset();
    ex(13, F_STATE, 3); ex(21, F_READY, 1); ex(21, F_LOST, 0);
    ex(22, F_READY, 0); ex(22, F_LOST, 1); ex(22, F_STATE, 0); ex(22, F_ARESET, 1);
    ex(25, F_ARESET, 1); ex(26, F_ARESET, 0); ex(26, F_STATE, 1);
    ex(35, F_STATE, 3); ex(35, F_READY, 1); ex(35, F_LOST, 1); ex(35, F_RETRY, 0);
    ex(36, F_LOST, 1); ex(37, F_LOST, 0);
    for (int c = 1; c <= 37; c++) begin
      bus.locked_in = (c != 20);
      bus.clr_lost  = (c == 37);
      tick();
      bus.clr_lost = 1'b0;
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        act = fld(e.sel);
        n_cmp++;
        if (act !== 32'(e.val)) begin
          n_bad++;
          $display("FAIL lock_loss %s @c%0d: got %0d, want %0d", fname(e.sel), c, act, e.val);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    exp_t e;
    logic [31:0] act;
    do_reset();
    ex(21, F_STATE, 3);
    ex(22, F_STATE, 0); ex(22, F_LOST, 1); ex(22, F_RETRY, 0); ex(22, F_READY, 0); ex(22, F_ARESET, 1);
    ex(23, F_LOST, 1); ex(23, F_STATE, 0);
    for (int c = 1; c <= 23; c++) begin
      bus.locked_in = (c != 20);
      bus.restart   = (c == 22);
      bus.clr_lost  = (c == 22);
      tick();
      bus.restart  = 1'b0;
      bus.clr_lost = 1'b0;
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        act = fld(e.sel);
        n_cmp++;
        if (act !== 32'(e.val)) begin
          n_bad++;
          $display("FAIL simultaneous %s @c%0d: got %0d, want %0d", fname(e.sel), c, act, e.val);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    logic [31:0] act;
    // Reset while qualifying lock in STABLE.
    do_reset();
    ex(7, F_STATE, 2); ex(7, F_ARESET, 0);
    ex(8, F_STATE, 0); ex(8, F_ARESET, 1); ex(8, F_READY, 0); ex(8, F_FAIL, 0); ex(8, F_RETRY, 0);
    for (int c = 1; c <= 8; c++) begin
      bus.locked_in = 1'b1;
      rst_n = (c != 8);
      tick();
      rst_n = 1'b1;
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        act = fld(e.sel);
        n_cmp++;
        if (act !== 32'(e.val)) begin
          n_bad++;
          $display("FAIL mid_reset_stable %s @c%0d: got %0d, want %0d", fname(e.sel), c, act, e.val);
        end
      end
    end
    // Reset while waiting for lock on the second attempt.
    do_reset();
    ex(34, F_STATE, 1); ex(34, F_RETRY, 1);
    ex(35, F_STATE, 0); ex(35, F_RETRY, 0); ex(35, F_ARESET, 1);
    ex(35, F_READY, 0); ex(35, F_FAIL, 0); ex(35, F_LOST, 0);
    for (int c = 1; c <= 35; c++) begin
      rst_n = (c != 35);
      tick();
      rst_n = 1'b1;
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        act = fld(e.sel);
        n_cmp++;
        if (act !== 32'(e.val)) begin
          n_bad++;
          $display("FAIL mid_reset_wait %s @c%0d: got %0d, want %0d", fname(e.sel), c, act, e.val);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock_basic();
    test_timeout_fail();
    test_glitch();
    test_lock_loss();
    test_simultaneous();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end
endmodule
